multibyte_add_seq: RTL and testbench

//  Sequential multi-precision adder. Accepts two NBYTES-wide operands over a valid/ready

---
 rtl/multibyte_add_seq_if.sv | 42 ++++
 rtl/multibyte_add_seq.sv | 120 ++++++++++++
 tb/tb_multibyte_add_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/multibyte_add_seq_if.sv
// Handshake bundle for multibyte_add_seq: operand channel (in_*), result
// channel (out_*) and status. The optional subtract control is present only
// when MBADD_SUB_EN is defined.
interface multibyte_add_seq_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef MBADD_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

`ifdef MBADD_SUB_EN
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
`endif
endinterface

// File: rtl/multibyte_add_seq.sv
// Sequential multi-precision adder: adds two NBYTES-wide operands one byte per
// cycle through an 8-bit byte adder, rippling the carry through a register.
// Optional feature macro: MBADD_SUB_EN (adds the sub control, a-b = a+~b+1).
module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input logic               clk,
    input logic               rst_n,
    multibyte_add_seq_if.slave bus
);
    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 8-bit byte adder; returns {carry out of bit 7, carry into bit 7, sum byte}
    function automatic logic [9:0] byte_add(input logic [7:0] x, input logic [7:0] y,
                                            input logic cin);
        logic [8:0] s;
        logic       c7;
        s  = {1'b0, x} + {1'b0, y} + {8'd0, cin};
        c7 = x[7] ^ y[7] ^ s[7];
        return {s[8], c7, s[7:0]};
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_cout;
    logic            r_ovf;
    logic [IDXW-1:0] r_idx;

    logic [9:0]      w_byte;
    logic [W-1:0]    w_acc_next;
    logic            w_last;

    assign w_byte     = byte_add(r_a[7:0], r_b[7:0], r_carry);
    // New byte enters at the MSB end; the widened shift also covers NBYTES=1.
    assign w_acc_next = W'({w_byte[7:0], r_acc} >> 8);
    assign w_last     = (r_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept only in IDLE, release result only from DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)        w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands, ripple one byte per RUN cycle, latch result on last byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a   <= bus.a;
                        r_idx <= '0;
`ifdef MBADD_SUB_EN
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub;
`else
                        r_b     <= bus.b;
                        r_carry <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_a     <= r_a >> 8;
                    r_b     <= r_b >> 8;
                    r_carry <= w_byte[9];
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_sum  <= w_acc_next;
                        r_cout <= w_byte[9];
                        r_ovf  <= w_byte[9] ^ w_byte[8];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench for multibyte_add_seq: an NBYTES=4 instance for the main
// tests and an NBYTES=1 instance for the single-byte / minimum-interval tests.
// Subtract tests are included when MBADD_SUB_EN is defined.
module tb_multibyte_add_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    multibyte_add_seq_if #(.NBYTES(4)) b4 ();
    multibyte_add_seq_if #(.NBYTES(1)) b1 ();

    multibyte_add_seq #(.NBYTES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    multibyte_add_seq #(.NBYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: {cout, ovf, sum}
    function automatic logic [129:0] model(input logic [127:0] a, input logic [127:0] b,
                                           input int w, input bit s);
        logic [127:0] mask, aa, be, sm;
        logic [128:0] full;
        logic         c, o;
        mask = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
        aa   = a & mask;
        be   = (s ? ~b : b) & mask;
        full = {1'b0, aa} + {1'b0, be} + 129'(s);
        sm   = full[127:0] & mask;
        c    = full[w];
        o    = (aa[w-1] == be[w-1]) && (sm[w-1] != aa[w-1]);
        return {c, o, sm};
    endfunction

    task automatic set_sub4(input bit s);
`ifdef MBADD_SUB_EN
        b4.sub = s;
`else
        if (s) $display("note: subtract not built");
`endif
    endtask

    task automatic set_sub1(input bit s);
`ifdef MBADD_SUB_EN
        b1.sub = s;
`else
        if (s) $display("note: subtract not built");
`endif
    endtask

    // One transaction on the 4-byte instance; hold = cycles of backpressure in DONE
    task automatic txn4(input logic [31:0] a, input logic [31:0] b, input bit s, input int hold);
        logic [129:0] e;
        e = model({96'd0, a}, {96'd0, b}, W, s);
        chk("in_ready_idle", b4.in_ready, 1);
        b4.in_valid = 1'b1;
        b4.a = a;
        b4.b = b;
        set_sub4(s);
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        b4.a = $urandom;
        b4.b = $urandom;
        chk("busy_run", b4.busy, 1);
        repeat (NB - 1) begin
            @(posedge clk); #1;
        end
        chk("early_valid", b4.out_valid, 0);
        @(posedge clk); #1;
        chk("out_valid", b4.out_valid, 1);
        chk("sum", b4.sum, e[127:0]);
        chk("cout", b4.cout, e[129]);
        chk("ovf", b4.ovf, e[128]);
        for (int i = 0; i < hold; i++) begin
            b4.in_valid = 1'b1;
            b4.a = $urandom;
            b4.b = $urandom;
            @(posedge clk); #1;
            chk("bp_valid", b4.out_valid, 1);
            chk("bp_sum", b4.sum, e[127:0]);
            chk("bp_in_ready", b4.in_ready, 0);
        end
        b4.out_ready = 1'b1;
        @(posedge clk); #1;
        b4.out_ready = 1'b0;
        b4.in_valid  = 1'b0;
        chk("idle_after_release", b4.in_ready, 1);
        chk("valid_after_release", b4.out_valid, 0);
        chk("sum_hold", b4.sum, e[127:0]);
    endtask

    initial begin
        logic [129:0] e;
        logic [7:0]   oa, ob;
        bit           s;

        b4.in_valid = 1'b0; b4.a = '0; b4.b = '0; b4.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.out_ready = 1'b0;
        set_sub4(0);
        set_sub1(0);

        // reset state, with in_valid asserted during reset
        #3;
        b4.in_valid = 1'b1;
        b4.a = 32'hDEADBEEF;
        b4.b = 32'h01020304;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", b4.in_ready, 1);
        chk("rst_out_valid", b4.out_valid, 0);
        chk("rst_busy", b4.busy, 0);
        chk("rst_sum", b4.sum, 0);
        chk("rst_cout", b4.cout, 0);
        chk("rst_ovf", b4.ovf, 0);
        b4.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", b4.busy, 0);

        // directed adds
        txn4(32'hFFFFFFFF, 32'h00000001, 0, 0);
        txn4(32'h7FFFFFFF, 32'h00000001, 0, 0);
        txn4(32'h80000000, 32'h80000000, 0, 0);
        txn4(32'h12345678, 32'h11111111, 0, 10);

        // randomized adds (and subtracts when built)
        for (int k = 0; k < 16; k++) begin
            s = 1'b0;
`ifdef MBADD_SUB_EN
            s = $urandom_range(0, 1);
`endif
            txn4($urandom, $urandom, s, $urandom_range(0, 2));
        end

`ifdef MBADD_SUB_EN
        txn4(32'd5, 32'd7, 1, 0);
        txn4(32'd7, 32'd5, 1, 0);
        txn4(32'h80000000, 32'd1, 1, 0);
`endif

        // reset in the middle of RUN, after a nonzero result is held
        txn4(32'h12345678, 32'h11111111, 0, 0);
        b4.in_valid = 1'b1;
        b4.a = 32'hA5A5A5A5;
        b4.b = 32'h5A5A5A5A;
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", b4.sum, 0);
        chk("mid_rst_cout", b4.cout, 0);
        chk("mid_rst_ovf", b4.ovf, 0);
        chk("mid_rst_valid", b4.out_valid, 0);
        chk("mid_rst_in_ready", b4.in_ready, 1);
        chk("mid_rst_busy", b4.busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NB + 2; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", b4.out_valid, 0);
            chk("post_rst_in_ready", b4.in_ready, 1);
        end
        txn4(32'h0000FFFF, 32'h00000001, 0, 0);

        // NBYTES=1: one-cycle RUN, back-to-back at the 3-cycle minimum interval
        b1.in_valid  = 1'b1;
        b1.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            oa = (k == 0) ? 8'h80 : 8'($urandom);
            ob = (k == 0) ? 8'h80 : 8'($urandom);
            s  = 1'b0;
`ifdef MBADD_SUB_EN
            if (k > 0) s = $urandom_range(0, 1);
`endif
            e = model({120'd0, oa}, {120'd0, ob}, 8, s);
            b1.a = oa;
            b1.b = ob;
            set_sub1(s);
            chk("b1_in_ready", b1.in_ready, 1);
            @(posedge clk); #1;
            chk("b1_busy", b1.busy, 1);
            chk("b1_no_early_valid", b1.out_valid, 0);
            b1.a = 8'($urandom);
            b1.b = 8'($urandom);
            @(posedge clk); #1;
            chk("b1_out_valid", b1.out_valid, 1);
            chk("b1_sum", b1.sum, e[127:0]);
            chk("b1_cout", b1.cout, e[129]);
            chk("b1_ovf", b1.ovf, e[128]);
            chk("b1_done_in_ready", b1.in_ready, 0);
            @(posedge clk); #1;
            chk("b1_idle_valid", b1.out_valid, 0);
            chk("b1_sum_hold", b1.sum, e[127:0]);
        end
        b1.in_valid  = 1'b0;
        b1.out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
